sys_ctrl_regs: RTL and testbench

SYS_CTRL_REGS -- requirements
Module: sys_ctrl_regs

---
 rtl/sys_ctrl_regs_if.sv | 12 +
 rtl/sys_ctrl_regs.sv | 168 ++++++++++++++++
 tb/tb_sys_ctrl_regs.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/sys_ctrl_regs_if.sv
// Register-bus bundle for sys_ctrl_regs: byte address, write data, byte-lane
// write strobes and combinational read data.
interface sys_ctrl_regs_if;
   logic [12:0] addr;
   logic [31:0] dataIn;
   logic [31:0] dataOut;
   logic        cs;
   logic        wr0, wr1, wr2, wr3;

   modport master (output addr, dataIn, cs, wr0, wr1, wr2, wr3, input dataOut);
   modport slave  (input addr, dataIn, cs, wr0, wr1, wr2, wr3, output dataOut);
endinterface

// File: rtl/sys_ctrl_regs.sv
// System control register block: ID/version readback, soft-reset pulse, DAC/output
// mux selects and a keyed reboot sequencer. Define SYS_REBOOT_KEY_EN to gate reboot with an unlock key.
module sys_ctrl_byte_reg #(
   parameter logic [7:0] MASK = 8'hFF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       we,
   input  logic [7:0] d,
   output logic [7:0] q
);
   always_ff @(posedge clk) begin
      if (reset)   q <= '0;
      else if (we) q <= d & MASK;
   end
endmodule

module sys_ctrl_regs #(
   parameter int NUM_DAC      = 3,
   parameter int NUM_CH       = 2,
   parameter int RST_LEN      = 6,
   parameter int KEY_WINDOW   = 64,
   parameter int REBOOT_DELAY = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   sys_ctrl_regs_if.slave        bus,
   input  logic [15:0]           versionNumber,
   input  logic [15:0]           fpgaType,
   input  logic [8:0]            idCode,
   output logic                  softReset,
   output logic                  reboot,
   output logic [31:0]           rebootAddress,
   output logic [4*NUM_DAC-1:0]  dacSel,
   output logic [4*NUM_CH-1:0]   chSel
);
   // Select nibbles beyond the configured count are held at zero by the lane masks.
   localparam logic [31:0] DAC_MASK = 32'hFFFF_FFFF >> (32 - 4*NUM_DAC);
   localparam logic [31:0] CH_MASK  = 32'hFFFF_FFFF >> (32 - 4*NUM_CH);

   typedef enum logic [1:0] {IDLE = 2'd0, UNLOCKED = 2'd1, HOLD = 2'd2, PULSE = 2'd3} state_t;
   state_t state, state_nxt;

   logic [3:0]  wr;
   logic [2:0]  off;
   logic [7:0]  sel;
   logic [31:0] ra_q, dac_q, ch_q, rdata;
   logic [7:0]  rst_cnt, dly_cnt;
   logic [15:0] win_cnt;
   logic        trig, key_wr, key_ok, key_fail, kf_set, kf_clr;
   logic        unused;

   assign wr     = {bus.wr3, bus.wr2, bus.wr1, bus.wr0};
   assign off    = bus.addr[4:2];
   assign sel    = bus.cs ? (8'd1 << off) : 8'd0;
   assign trig   = sel[2] & wr[3];
   assign unused = ^{bus.addr[12:5], bus.addr[1:0], dac_q, ch_q};

   for (genvar n = 0; n < 4; n++) begin : g_lane
      sys_ctrl_byte_reg u_ra (
         .clk(clk), .reset(reset), .we(sel[2] & wr[n]),
         .d(bus.dataIn[8*n +: 8]), .q(ra_q[8*n +: 8]));
      sys_ctrl_byte_reg #(.MASK(DAC_MASK[8*n +: 8])) u_dac (
         .clk(clk), .reset(reset), .we(sel[4] & wr[n]),
         .d(bus.dataIn[8*n +: 8]), .q(dac_q[8*n +: 8]));
      sys_ctrl_byte_reg #(.MASK(CH_MASK[8*n +: 8])) u_ch (
         .clk(clk), .reset(reset), .we(sel[5] & wr[n]),
         .d(bus.dataIn[8*n +: 8]), .q(ch_q[8*n +: 8]));
   end

`ifdef SYS_REBOOT_KEY_EN
   localparam logic [31:0] KEY = 32'h5EC0_B007;
   logic [31:0] key_q;

   for (genvar n = 0; n < 4; n++) begin : g_key
      sys_ctrl_byte_reg u_key (
         .clk(clk), .reset(reset), .we(sel[3] & wr[n]),
         .d(bus.dataIn[8*n +: 8]), .q(key_q[8*n +: 8]));
   end

   assign key_wr = sel[3] & (&wr);
   assign key_ok = key_wr & (bus.dataIn == KEY);
   assign kf_set = ((state == UNLOCKED) & key_wr & ~key_ok) | ((state == IDLE) & trig);
`else
   assign key_wr = 1'b0;
   assign key_ok = 1'b0;
   assign kf_set = 1'b0;
`endif

   assign kf_clr = sel[6] & wr[0] & bus.dataIn[4];

   // Reboot sequencer: state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Reboot sequencer: next state
   always_comb begin
      state_nxt = state;
      case (state)
`ifdef SYS_REBOOT_KEY_EN
         IDLE:     if (key_ok) state_nxt = UNLOCKED;
`else
         IDLE:     if (trig)   state_nxt = HOLD;
`endif
         UNLOCKED: begin
            if (trig)                   state_nxt = HOLD;
            else if (key_wr && !key_ok) state_nxt = IDLE;
            else if (win_cnt <= 16'd1)  state_nxt = IDLE;
         end
         HOLD:     if (dly_cnt <= 8'd1) state_nxt = PULSE;
         PULSE:    state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // Reboot sequencer / soft reset: outputs
   always_comb begin
      reboot    = (state == PULSE);
      softReset = (rst_cnt != 8'd0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rst_cnt  <= '0;
         win_cnt  <= '0;
         dly_cnt  <= '0;
         key_fail <= 1'b0;
      end else begin
         if (sel[0] && wr[0])        rst_cnt <= 8'(RST_LEN);
         else if (rst_cnt != 8'd0)   rst_cnt <= rst_cnt - 8'd1;

         if (state == IDLE && key_ok)                   win_cnt <= 16'(KEY_WINDOW);
         else if (state == UNLOCKED && win_cnt != 16'd0) win_cnt <= win_cnt - 16'd1;

         if (state_nxt == HOLD && state != HOLD)         dly_cnt <= 8'(REBOOT_DELAY);
         else if (state == HOLD && dly_cnt != 8'd0)      dly_cnt <= dly_cnt - 8'd1;

         // A set wins over a clear landing in the same cycle.
         if (kf_set)      key_fail <= 1'b1;
         else if (kf_clr) key_fail <= 1'b0;
      end
   end

   always_comb begin
      rdata = '0;
      if (bus.cs) begin
         case (off)
            3'd0: rdata = {versionNumber, 16'h0};
            3'd1: rdata = {7'h0, idCode, fpgaType};
            3'd2: rdata = ra_q;
`ifdef SYS_REBOOT_KEY_EN
            3'd3: rdata = key_q;
`endif
            3'd4: rdata = dac_q;
            3'd5: rdata = ch_q;
            3'd6: rdata = {27'h0, key_fail, softReset, 1'b0, state};
            default: rdata = '0;
         endcase
      end
   end

   assign bus.dataOut   = rdata;
   assign rebootAddress = ra_q;
   assign dacSel        = dac_q[4*NUM_DAC-1:0];
   assign chSel         = ch_q[4*NUM_CH-1:0];
endmodule

// File: tb/tb_sys_ctrl_regs.sv
// Randomized scoreboard bench for sys_ctrl_regs: a timestamp-based reference model
// predicts every cycle's outputs; a negedge monitor pops and compares.
module tb_sys_ctrl_regs;
   localparam int ND = 3, NC = 2, RL = 6, KW = 64, RD = 16;
`ifdef SYS_REBOOT_KEY_EN
   localparam bit KEY_EN = 1'b1;
`else
   localparam bit KEY_EN = 1'b0;
`endif
   localparam logic [31:0] KEY = 32'h5EC0_B007;
   localparam logic [31:0] DM  = 32'((64'd1 << (4*ND)) - 64'd1);
   localparam logic [31:0] CM  = 32'((64'd1 << (4*NC)) - 64'd1);

   logic clk = 1'b0;
   logic reset;
   logic [15:0] ver, ftype;
   logic [8:0] idc;
   logic soft_rst, rbt;
   logic [31:0] radr;
   logic [4*ND-1:0] dac;
   logic [4*NC-1:0] ch;

   sys_ctrl_regs_if bus();

   sys_ctrl_regs #(.NUM_DAC(ND), .NUM_CH(NC), .RST_LEN(RL), .KEY_WINDOW(KW), .REBOOT_DELAY(RD)) dut (
      .clk(clk), .reset(reset), .bus(bus), .versionNumber(ver), .fpgaType(ftype), .idCode(idc),
      .softReset(soft_rst), .reboot(rbt), .rebootAddress(radr), .dacSel(dac), .chSel(ch));

   always #5 clk = ~clk;

   typedef struct {
      logic        sr, rb;
      logic [31:0] ra, dac, ch, rd;
   } exp_t;
   exp_t q[$];

   int checks = 0, errors = 0;

   // Reference model: events are remembered by the cycle they happened in.
   int cyc = 0, sr_last = -1, trig = -1000, unl_from = -1, unl_until = -1;
   bit armed = 1'b0, m_kf = 1'b0;
   logic [31:0] m_ra = '0, m_dac = '0, m_ch = '0, m_key = '0;

   function automatic int st(input int c);
      if (c > trig && c <= trig + RD) return 2;
      if (c == trig + RD + 1)        return 3;
      if (c > unl_from && c <= unl_until) return 1;
      return 0;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] w, input logic [31:0] m);
      logic [31:0] r = old;
      for (int n = 0; n < 4; n++) if (w[n]) r[8*n +: 8] = d[8*n +: 8];
      return r & m;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle-time %0t actual %h expected %h", nm, $time, act, exp);
      end
   endtask

   task automatic step(input bit r, input bit c, input logic [2:0] o,
                       input logic [31:0] d, input logic [3:0] w);
      exp_t e;
      int s;
      @(posedge clk); #1;
      reset = r;
      bus.cs = c;
      bus.addr = {8'($urandom), o, 2'($urandom)};
      bus.dataIn = d;
      {bus.wr3, bus.wr2, bus.wr1, bus.wr0} = c ? w : 4'($urandom);
      s = st(cyc);
      if (armed) begin
         e.sr = (cyc <= sr_last);
         e.rb = (s == 3);
         e.ra = m_ra; e.dac = m_dac; e.ch = m_ch;
         e.rd = '0;
         if (c) begin
            case (o)
               3'd0: e.rd = {ver, 16'h0};
               3'd1: e.rd = {7'h0, idc, ftype};
               3'd2: e.rd = m_ra;
               3'd3: e.rd = KEY_EN ? m_key : 32'h0;
               3'd4: e.rd = m_dac;
               3'd5: e.rd = m_ch;
               3'd6: e.rd = {27'h0, m_kf, e.sr, 1'b0, 2'(s)};
               default: e.rd = '0;
            endcase
         end
         q.push_back(e);
      end
      if (r) begin
         armed = 1'b1; sr_last = -1; trig = -1000; unl_until = -1; m_kf = 1'b0;
         m_ra = '0; m_dac = '0; m_ch = '0; m_key = '0;
      end else if (c) begin
         case (o)
            3'd0: if (w[0]) sr_last = cyc + RL;
            3'd2: begin
               m_ra = merge(m_ra, d, w, 32'hFFFF_FFFF);
               if (w[3]) begin
                  if (KEY_EN) begin
                     if (s == 1) begin trig = cyc; unl_until = cyc; end
                     else if (s == 0) m_kf = 1'b1;
                  end else if (s == 0) trig = cyc;
               end
            end
            3'd3: if (KEY_EN) begin
               m_key = merge(m_key, d, w, 32'hFFFF_FFFF);
               if (w == 4'hF) begin
                  if (s == 0 && d == KEY) begin unl_from = cyc; unl_until = cyc + KW; end
                  else if (s == 1 && d != KEY) begin unl_until = cyc; m_kf = 1'b1; end
               end
            end
            3'd4: m_dac = merge(m_dac, d, w, DM);
            3'd5: m_ch  = merge(m_ch, d, w, CM);
            3'd6: if (w[0] && d[4]) m_kf = 1'b0;
            default: ;
         endcase
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
   endtask

   task automatic rd(input logic [2:0] o);
      step(1'b0, 1'b1, o, $urandom, 4'h0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("softReset", 32'(soft_rst), 32'(e.sr));
         chk("reboot", 32'(rbt), 32'(e.rb));
         chk("rebootAddress", radr, e.ra);
         chk("dacSel", 32'(dac), e.dac);
         chk("chSel", 32'(ch), e.ch);
         chk("dataOut", bus.dataOut, e.rd);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      logic [2:0] o;
      logic [31:0] d;
      logic [3:0] w;
      reset = 1'b1; bus.cs = 1'b0; bus.addr = '0; bus.dataIn = '0;
      {bus.wr3, bus.wr2, bus.wr1, bus.wr0} = 4'h0;
      ver = 16'($urandom); ftype = 16'($urandom); idc = 9'($urandom);

      step(1'b1, 1'b0, 3'd0, 32'h0, 4'h0);
      step(1'b1, 1'b0, 3'd0, 32'h0, 4'h0);
      for (int i = 0; i < 8; i++) rd(3'(i));

      // Select masking, then soft-reset pulse with a mid-pulse reload
      step(1'b0, 1'b1, 3'd4, 32'hFFFF_FFFF, 4'hF); rd(3'd4);
      step(1'b0, 1'b1, 3'd5, 32'hFFFF_FFFF, 4'hF); rd(3'd5);
      step(1'b0, 1'b1, 3'd0, 32'h0, 4'h1); idle(2);
      step(1'b0, 1'b1, 3'd0, 32'h0, 4'h1); rd(3'd6); idle(10);

      // Reboot trigger (after unlock when keyed), then timeout / key-fail path
`ifdef SYS_REBOOT_KEY_EN
      step(1'b0, 1'b1, 3'd3, KEY, 4'hF); idle(9);
`endif
      step(1'b0, 1'b1, 3'd2, 32'h12AB_CDEF, 4'h8);
      for (int i = 0; i < 20; i++) rd(3'd6);
`ifdef SYS_REBOOT_KEY_EN
      step(1'b0, 1'b1, 3'd3, KEY, 4'hF); idle(70); rd(3'd6);
      step(1'b0, 1'b1, 3'd2, 32'h3400_0000, 4'h8); rd(3'd6); idle(20);
      step(1'b0, 1'b1, 3'd6, 32'h10, 4'h1); rd(3'd6);
      step(1'b0, 1'b1, 3'd3, KEY, 4'hF);
      step(1'b0, 1'b1, 3'd3, 32'h1234_5678, 4'hF); rd(3'd6);
      step(1'b0, 1'b1, 3'd3, KEY, 4'hF);
`endif
      // Reset in the middle of HOLD aborts the reboot
      step(1'b0, 1'b1, 3'd2, 32'h5600_0000, 4'h8); idle(5);
      step(1'b1, 1'b0, 3'd0, 32'h0, 4'h0);
      for (int i = 0; i < 25; i++) rd(3'd6);

      for (int i = 0; i < 3000; i++) begin
         k = $urandom_range(0, 99);
         o = 3'($urandom); d = $urandom; w = 4'($urandom);
         if (k < 1)       step(1'b1, 1'b0, 3'd0, 32'h0, 4'h0);
         else if (k < 8)  step(1'b0, 1'b1, 3'd3, ($urandom_range(0, 1) != 0) ? KEY : d, 4'hF);
         else if (k < 13) step(1'b0, 1'b1, 3'd2, d, w | 4'h8);
         else if (k < 16) step(1'b0, 1'b1, 3'd0, d, w | 4'h1);
         else if (k < 19) step(1'b0, 1'b1, 3'd6, d | 32'h10, w | 4'h1);
         else if (k < 45) step(1'b0, 1'b1, o, d, 4'h0);
         else if (k < 70) step(1'b0, 1'b0, o, d, w);
         else             step(1'b0, 1'b1, o, d, w);
      end
      idle(2);
      @(negedge clk); #1;
      chk("scoreboard-drained", 32'(q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
